idct_col_stage: RTL and testbench

//  Second-pass (column) 1-D inverse transform. Sits directly downstream of the

---
 rtl/idct_col_stage.sv | 184 ++++++++++++++++++
 tb/tb_idct_col_stage.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/idct_col_stage.sv
// Column-pass HEVC partial-butterfly inverse DCT (4/8-point) with round, shift and width reduction.
// Define IDCT_CLIP_EN to saturate residuals; otherwise they wrap to OUT_WIDTH bits.
module idct_col_stage #(
  parameter int WIDTH_X   = 16,
  parameter int OUT_WIDTH = 9,
  parameter int SHIFT     = 12
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [1:0]                  mode_in,
  input  logic signed [WIDTH_X-1:0]   d_in,
  output logic [1:0]                  mode_out,
  output logic                        out_valid,
  output logic signed [OUT_WIDTH-1:0] d_out
);

  localparam int ACC_W = WIDTH_X + 10;

  localparam logic signed [ACC_W-1:0] C89 = ACC_W'(89);
  localparam logic signed [ACC_W-1:0] C83 = ACC_W'(83);
  localparam logic signed [ACC_W-1:0] C75 = ACC_W'(75);
  localparam logic signed [ACC_W-1:0] C64 = ACC_W'(64);
  localparam logic signed [ACC_W-1:0] C50 = ACC_W'(50);
  localparam logic signed [ACC_W-1:0] C36 = ACC_W'(36);
  localparam logic signed [ACC_W-1:0] C18 = ACC_W'(18);
  localparam logic signed [ACC_W-1:0] RND  = ACC_W'(1) << (SHIFT - 1);
  localparam logic signed [ACC_W-1:0] OMAX = (ACC_W'(1) << (OUT_WIDTH - 1)) - ACC_W'(1);
  localparam logic signed [ACC_W-1:0] OMIN = -OMAX - ACC_W'(1);

  function automatic logic signed [ACC_W-1:0] sext(input logic signed [WIDTH_X-1:0] v);
    return {{(ACC_W - WIDTH_X){v[WIDTH_X-1]}}, v};
  endfunction

  // Round half up, then floor via arithmetic shift.
  function automatic logic signed [ACC_W-1:0] rnd_shift(input logic signed [ACC_W-1:0] y);
    return (y + RND) >>> SHIFT;
  endfunction

  function automatic logic signed [OUT_WIDTH-1:0] narrow(input logic signed [ACC_W-1:0] r);
`ifdef IDCT_CLIP_EN
    if (r > OMAX) return OMAX[OUT_WIDTH-1:0];
    if (r < OMIN) return OMIN[OUT_WIDTH-1:0];
    return r[OUT_WIDTH-1:0];
`else
    return r[OUT_WIDTH-1:0];
`endif
  endfunction

  // Input collection
  logic [2:0]                 r_cnt;
  logic [1:0]                 r_vec_mode;
  logic signed [WIDTH_X-1:0]  r_x [8];

  logic                       w_accept;
  logic                       w_restart;
  logic                       w_done;
  logic [2:0]                 w_last;
  logic [2:0]                 w_slot;
  logic signed [WIDTH_X-1:0]  w_xfull [8];

  always_comb begin
    w_accept  = (mode_in != 2'b00);
    w_last    = mode_in[0] ? 3'd3 : 3'd7;
    w_restart = w_accept && (r_cnt != 3'd0) && (mode_in != r_vec_mode);
    w_slot    = w_restart ? 3'd0 : r_cnt;
    w_done    = w_accept && (w_slot == w_last);
    w_xfull   = r_x;
    w_xfull[w_slot] = d_in;
  end

  // Stage p0: completed vector registered for compute
  logic signed [WIDTH_X-1:0]  r_x_p0 [8];
  logic                       r_vld_p0;
  logic [1:0]                 r_tag_p0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt      <= 3'd0;
      r_vec_mode <= 2'b00;
      r_vld_p0   <= 1'b0;
      r_tag_p0   <= 2'b00;
      for (int i = 0; i < 8; i++) begin
        r_x[i]    <= '0;
        r_x_p0[i] <= '0;
      end
    end else begin
      r_vld_p0 <= w_done;
      if (w_accept) begin
        r_x[w_slot] <= d_in;
        r_cnt       <= w_done ? 3'd0 : w_slot + 3'd1;
        if (w_slot == 3'd0) r_vec_mode <= mode_in;
      end else begin
        r_cnt <= 3'd0;
      end
      if (w_done) begin
        r_x_p0   <= w_xfull;
        r_tag_p0 <= mode_in;
      end
    end
  end

  // Butterfly on the p0 vector; the even core serves as the whole 4-point transform
  logic                       w_is4;
  logic signed [ACC_W-1:0]    w_ea, w_eb, w_ec, w_ed;
  logic signed [ACC_W-1:0]    w_e0, w_e1, w_o0, w_o1;
  logic signed [ACC_W-1:0]    w_p1, w_p3, w_p5, w_p7;
  logic signed [ACC_W-1:0]    w_ee [4];
  logic signed [ACC_W-1:0]    w_od [4];
  logic signed [ACC_W-1:0]    w_y  [8];
  logic signed [OUT_WIDTH-1:0] w_res [8];

  always_comb begin
    w_is4 = r_tag_p0[0];
    w_ea  = sext(r_x_p0[0]);
    w_eb  = w_is4 ? sext(r_x_p0[1]) : sext(r_x_p0[2]);
    w_ec  = w_is4 ? sext(r_x_p0[2]) : sext(r_x_p0[4]);
    w_ed  = w_is4 ? sext(r_x_p0[3]) : sext(r_x_p0[6]);
    w_e0  = C64 * (w_ea + w_ec);
    w_e1  = C64 * (w_ea - w_ec);
    w_o0  = C83 * w_eb + C36 * w_ed;
    w_o1  = C36 * w_eb - C83 * w_ed;
    w_ee[0] = w_e0 + w_o0;
    w_ee[1] = w_e1 + w_o1;
    w_ee[2] = w_e1 - w_o1;
    w_ee[3] = w_e0 - w_o0;

    w_p1 = sext(r_x_p0[1]);
    w_p3 = sext(r_x_p0[3]);
    w_p5 = sext(r_x_p0[5]);
    w_p7 = sext(r_x_p0[7]);
    w_od[0] = C89 * w_p1 + C75 * w_p3 + C50 * w_p5 + C18 * w_p7;
    w_od[1] = C75 * w_p1 - C18 * w_p3 - C89 * w_p5 - C50 * w_p7;
    w_od[2] = C50 * w_p1 - C89 * w_p3 + C18 * w_p5 + C75 * w_p7;
    w_od[3] = C18 * w_p1 - C50 * w_p3 + C75 * w_p5 - C89 * w_p7;

    for (int k = 0; k < 8; k++) w_y[k] = '0;
    for (int k = 0; k < 4; k++) begin
      if (w_is4) begin
        w_y[k] = w_ee[k];
      end else begin
        w_y[k]     = w_ee[k] + w_od[k];
        w_y[7 - k] = w_ee[k] - w_od[k];
      end
    end
    for (int k = 0; k < 8; k++) w_res[k] = narrow(rnd_shift(w_y[k]));
  end

  // Stage p1: output buffer and serializer; a fresh load always wins over draining
  logic signed [OUT_WIDTH-1:0] r_buf_p1 [8];
  logic [3:0]                  r_len_p1;
  logic [3:0]                  r_rd_p1;
  logic signed [OUT_WIDTH-1:0] r_d_out;
  logic                        r_out_valid;
  logic [1:0]                  r_mode_out;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_len_p1    <= 4'd0;
      r_rd_p1     <= 4'd0;
      r_d_out     <= '0;
      r_out_valid <= 1'b0;
      r_mode_out  <= 2'b00;
      for (int i = 0; i < 8; i++) r_buf_p1[i] <= '0;
    end else if (r_vld_p0) begin
      r_buf_p1    <= w_res;
      r_len_p1    <= w_is4 ? 4'd4 : 4'd8;
      r_rd_p1     <= 4'd1;
      r_d_out     <= w_res[0];
      r_out_valid <= 1'b1;
      r_mode_out  <= r_tag_p0;
    end else if (r_rd_p1 < r_len_p1) begin
      r_d_out     <= r_buf_p1[r_rd_p1[2:0]];
      r_rd_p1     <= r_rd_p1 + 4'd1;
      r_out_valid <= 1'b1;
    end else begin
      r_out_valid <= 1'b0;
    end
  end

  assign d_out     = r_d_out;
  assign out_valid = r_out_valid;
  assign mode_out  = r_mode_out;

endmodule

// File: tb/tb_idct_col_stage.sv
// Directed, table-driven bench for idct_col_stage; expected residuals are hand-computed.
module tb_idct_col_stage;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [1:0]        mode_in = 2'b00;
  logic signed [15:0] d_in = '0;
  logic [1:0]        mode_out;
  logic              out_valid;
  logic signed [8:0] d_out;

  idct_col_stage #(.WIDTH_X(16), .OUT_WIDTH(9), .SHIFT(12)) dut (
    .clk(clk), .rst_n(rst_n), .mode_in(mode_in), .d_in(d_in),
    .mode_out(mode_out), .out_valid(out_valid), .d_out(d_out)
  );

  always #5 clk = ~clk;

`ifdef IDCT_CLIP_EN
  localparam int CP = 255;
  localparam int CN = -256;
`else
  localparam int CP = 0;
  localparam int CN = 0;
`endif

  typedef struct packed {
    logic [1:0]       mode;
    logic [3:0]       n;
    logic [7:0][15:0] x;
    logic [7:0][15:0] y;
  } vec_t;

  typedef struct packed {
    int               cyc;
    logic [1:0]       m;
    logic signed [8:0] d;
  } obs_t;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_err = 0;
  obs_t oq[$];
  obs_t mon_o;
  vec_t tab[$];
  int   tx[8];
  int   ty[8];
  int   ey[16];
  int   em[16];
  int   t_last;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (out_valid) begin
      mon_o.cyc = cyc;
      mon_o.m   = mode_out;
      mon_o.d   = d_out;
      oq.push_back(mon_o);
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic add_vec(input logic [1:0] m, input int n);
    vec_t v;
    v = '0;
    v.mode = m;
    v.n    = 4'(n);
    for (int k = 0; k < 8; k++) begin
      v.x[k] = tx[k][15:0];
      v.y[k] = ty[k][15:0];
    end
    tab.push_back(v);
  endtask

  task automatic drive(input logic [1:0] m, input int x);
    @(posedge clk); #1;
    mode_in = m;
    d_in    = x[15:0];
    t_last  = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      mode_in = 2'b00;
      d_in    = '0;
    end
  endtask

  // Compares the captured output stream against ey/em; t0 is the cycle of the first expected output.
  task automatic check_q(input string nm, input int n, input int t0);
    chk({nm, " count"}, oq.size(), n);
    for (int k = 0; k < n && k < oq.size(); k++) begin
      chk($sformatf("%s y%0d", nm, k), int'($signed(oq[k].d)), ey[k]);
      chk($sformatf("%s mode%0d", nm, k), int'(oq[k].m), em[k]);
      chk($sformatf("%s cyc%0d", nm, k), oq[k].cyc, t0 + k);
    end
  endtask

  initial begin
    // Table: {mode, N, x0..x7, y0..y7}
    tx = '{64, 0, 0, 0, 0, 0, 0, 0};          ty = '{1, 1, 1, 1, 0, 0, 0, 0};          add_vec(2'b01, 4);
    tx = '{0, 64, 0, 0, 0, 0, 0, 0};          ty = '{1, 1, -1, -1, 0, 0, 0, 0};        add_vec(2'b01, 4);
    tx = '{0, 0, 64, 0, 0, 0, 0, 0};          ty = '{1, -1, -1, 1, 0, 0, 0, 0};        add_vec(2'b01, 4);
    tx = '{0, 0, 0, 64, 0, 0, 0, 0};          ty = '{1, -1, 1, -1, 0, 0, 0, 0};        add_vec(2'b01, 4);
    tx = '{640, 0, 0, 0, 0, 0, 0, 0};         ty = '{10, 10, 10, 10, 10, 10, 10, 10};  add_vec(2'b10, 8);
    tx = '{-640, 0, 0, 0, 0, 0, 0, 0};        ty = '{-10, -10, -10, -10, -10, -10, -10, -10}; add_vec(2'b10, 8);
    tx = '{0, 64, 0, 0, 0, 0, 0, 0};          ty = '{1, 1, 1, 0, 0, -1, -1, -1};       add_vec(2'b10, 8);
    tx = '{128, 0, 0, 0, 0, 0, 0, 0};         ty = '{2, 2, 2, 2, 0, 0, 0, 0};          add_vec(2'b11, 4);
    tx = '{32767, 0, 0, 0, 0, 0, 0, 0};       ty = '{CP, CP, CP, CP, 0, 0, 0, 0};      add_vec(2'b01, 4);
    tx = '{-32768, 0, 0, 0, 0, 0, 0, 0};      ty = '{CN, CN, CN, CN, 0, 0, 0, 0};      add_vec(2'b01, 4);

    // Reset state
    idle(3);
    chk("reset out_valid", int'(out_valid), 0);
    chk("reset d_out", int'(d_out), 0);
    chk("reset mode_out", int'(mode_out), 0);
    rst_n = 1'b1;
    idle(2);

    foreach (tab[i]) begin
      oq.delete();
      for (int k = 0; k < int'(tab[i].n); k++) drive(tab[i].mode, int'($signed(tab[i].x[k])));
      idle(int'(tab[i].n) + 4);
      for (int k = 0; k < 8; k++) begin
        ey[k] = int'($signed(tab[i].y[k]));
        em[k] = int'(tab[i].mode);
      end
      check_q($sformatf("vec%0d", i), int'(tab[i].n), t_last + 2);
    end

    // 8-point vector abandoned after 3 samples by a 4-point vector
    oq.delete();
    drive(2'b10, 1000); drive(2'b10, 2000); drive(2'b10, 3000);
    drive(2'b01, 64); drive(2'b01, 0); drive(2'b01, 0); drive(2'b01, 0);
    idle(10);
    for (int k = 0; k < 4; k++) begin ey[k] = 1; em[k] = 1; end
    check_q("abort_switch", 4, t_last + 2);

    // Partial vector dropped by idle, then a full 8-point vector from a clean counter
    oq.delete();
    for (int k = 0; k < 5; k++) drive(2'b10, 3000);
    idle(4);
    chk("abort_idle count", oq.size(), 0);
    drive(2'b10, 640);
    for (int k = 1; k < 8; k++) drive(2'b10, 0);
    idle(12);
    for (int k = 0; k < 8; k++) begin ey[k] = 10; em[k] = 2; end
    check_q("after_idle", 8, t_last + 2);

    // Back-to-back 4-point vectors stream without gaps
    oq.delete();
    drive(2'b01, 64); drive(2'b01, 0); drive(2'b01, 0); drive(2'b01, 0);
    begin
      int t1;
      t1 = t_last;
      drive(2'b01, 0); drive(2'b01, 64); drive(2'b01, 0); drive(2'b01, 0);
      idle(10);
      ey = '{1, 1, 1, 1, 1, 1, -1, -1, 0, 0, 0, 0, 0, 0, 0, 0};
      for (int k = 0; k < 8; k++) em[k] = 1;
      check_q("gapfree", 8, t1 + 2);
    end

    // 8->4 collision: the new vector cuts off the old one's tail
    oq.delete();
    drive(2'b10, 640);
    for (int k = 1; k < 8; k++) drive(2'b10, 0);
    begin
      int t8;
      t8 = t_last;
      drive(2'b01, 64); drive(2'b01, 0); drive(2'b01, 0); drive(2'b01, 0);
      idle(12);
      ey = '{10, 10, 10, 10, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
      em = '{2, 2, 2, 2, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
      check_q("collision", 8, t8 + 2);
    end
    chk("hold out_valid", int'(out_valid), 0);
    chk("hold d_out", int'(d_out), 1);
    chk("hold mode_out", int'(mode_out), 1);

    // Reset in the middle of an output drain
    oq.delete();
    drive(2'b10, 640);
    for (int k = 1; k < 8; k++) drive(2'b10, 0);
    idle(3);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst out_valid", int'(out_valid), 0);
    chk("midrst d_out", int'(d_out), 0);
    chk("midrst mode_out", int'(mode_out), 0);
    rst_n = 1'b1;
    idle(12);
    chk("midrst residue count", oq.size(), 2);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
